// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter sharing one uart_tx between two byte streams
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    input  logic                  s0_tlast,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    input  logic                  s1_tlast,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [1:0]            grant,
    output logic                  burst_err
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t          state, state_nx;
    logic            last, last_nx;
    logic [CW-1:0]   beat_cnt, beat_cnt_nx;
    logic            burst_err_nx;
    logic            own_last, beat, at_limit, rel;

    function automatic state_t pick(input logic v0, input logic v1, input logic p);
        return (v0 && v1) ? (p ? G0 : G1) : v0 ? G0 : v1 ? G1 : IDLE;
    endfunction

    assign grant     = {state == G1, state == G0};
    assign s0_tready = m_tready && state == G0;
    assign s1_tready = m_tready && state == G1;
    assign m_tvalid  = state == G0 ? s0_tvalid : state == G1 ? s1_tvalid : 1'b0;
    assign m_tdata   = state == G0 ? s0_tdata : state == G1 ? s1_tdata : '0;
    assign own_last  = state == G0 ? s0_tlast : state == G1 ? s1_tlast : 1'b0;
    assign beat      = m_tvalid && m_tready;
    assign at_limit  = beat_cnt == CW'(MAX_BURST - 1);
    assign rel       = beat && (own_last || at_limit);

    // next owner, pointer, burst count and watchdog pulse; release re-arbitrates with the updated pointer
    always_comb begin
        state_nx     = state;
        last_nx      = last;
        beat_cnt_nx  = beat_cnt;
        burst_err_nx = rel && !own_last;
        if (state == IDLE)
            state_nx = pick(s0_tvalid, s1_tvalid, last);
        else if (rel) begin
            last_nx     = state == G1;
            beat_cnt_nx = '0;
            state_nx    = pick(s0_tvalid, s1_tvalid, state == G1);
        end else if (beat)
            beat_cnt_nx = beat_cnt + CW'(1);
    end

    // state registers; reset abandons any packet in flight and favours requester 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            beat_cnt  <= beat_cnt_nx;
            burst_err <= burst_err_nx;
        end
    end
endmodule
